// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: source encoding and
// the round-robin successor helper.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_IMM = 2'd2
    } src_e;

    localparam int NUM_SRC = 3;

    // Source that follows s in the ALU -> LD -> IMM -> ALU rotation.
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_ALU: next_src = SRC_LD;
            SRC_LD:  next_src = SRC_IMM;
            default: next_src = SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle: ALU and load req/gnt channels plus the RIM
// immediate channel. The requester side is master, the arbiter is slave.
interface rf_write_arbiter_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic         alu_req;
    logic [D-1:0] alu_addr;
    logic [W-1:0] alu_data;
    logic         alu_gnt;

    logic         ld_req;
    logic [D-1:0] ld_addr;
    logic [W-1:0] ld_data;
    logic         ld_gnt;

    logic         imm_req;
    logic [W-1:0] imm_data;
    logic         imm_gnt;

    modport master (
        output alu_req, alu_addr, alu_data,
        output ld_req, ld_addr, ld_data,
        output imm_req, imm_data,
        input  alu_gnt, ld_gnt, imm_gnt
    );

    modport slave (
        input  alu_req, alu_addr, alu_data,
        input  ld_req, ld_addr, ld_data,
        input  imm_req, imm_data,
        output alu_gnt, ld_gnt, imm_gnt
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arb3.sv
// Three-way round-robin arbiter. Grant is combinational from the current
// pointer; the pointer advances past the winner on every grant.
module rr_arb3
    import rf_arb_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt,
    output src_e               winner
);

    src_e ptr_reg;
    src_e ptr_next;
    logic found;

    // Scan the requests starting at the pointer; first asserted one wins.
    always_comb begin
        gnt      = '0;
        winner   = SRC_ALU;
        found    = 1'b0;
        ptr_next = ptr_reg;
        for (int k = 0; k < NUM_SRC; k++) begin
            int         idx_int;
            logic [1:0] idx;
            idx_int = int'(ptr_reg) + k;
            if (idx_int >= NUM_SRC) begin
                idx_int = idx_int - NUM_SRC;
            end
            idx = idx_int[1:0];
            if (!found && RST_N && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = src_e'(idx);
                found    = 1'b1;
            end
        end
        if (found) begin
            ptr_next = next_src(winner);
        end
    end

    // Pointer register; returns to ALU on reset, holds when nothing wins.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_reg <= SRC_ALU;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin among ALU, load return and
// immediate loader, a registered write stage, and a pending-load scoreboard
// that produces read-hazard flags for decode.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    rf_write_arbiter_if.slave    wb,
    input  logic                 issue_valid,
    input  logic [D-1:0]         issue_addr,
    input  logic [D-1:0]         raddrA,
    input  logic [D-1:0]         raddrB,
    output logic                 hazardA,
    output logic                 hazardB,
    output logic                 rim_hazard,
    output logic                 write_en,
    output logic                 write_imm,
    output logic [D-1:0]         waddr,
    output logic [W-1:0]         data_in,
    output logic [W-1:0]         imm_in,
    output logic                 busy
);

    localparam int NREG = 2 ** D;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    src_e               winner;

    logic               write_en_reg;
    logic               write_imm_reg;
    logic               ld_stage_reg;
    logic [D-1:0]       waddr_reg;
    logic [W-1:0]       data_in_reg;
    logic [W-1:0]       imm_in_reg;

    logic [NREG-1:0]    pending_reg;
    logic [NREG-1:0]    pending_next;

    assign req = {wb.imm_req, wb.ld_req, wb.alu_req};

    rr_arb3 u_arb (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .req    (req),
        .gnt    (gnt),
        .winner (winner)
    );

    assign wb.alu_gnt = gnt[0];
    assign wb.ld_gnt  = gnt[1];
    assign wb.imm_gnt = gnt[2];

    // Write stage: capture the granted transfer for delivery next cycle.
    // Writes to register 0 consume the grant but never assert write_en.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            write_en_reg  <= 1'b0;
            write_imm_reg <= 1'b0;
            ld_stage_reg  <= 1'b0;
            waddr_reg     <= '0;
            data_in_reg   <= '0;
            imm_in_reg    <= '0;
        end else begin
            write_en_reg  <= 1'b0;
            write_imm_reg <= 1'b0;
            ld_stage_reg  <= 1'b0;
            if (|gnt) begin
                case (winner)
                    SRC_ALU: begin
                        write_en_reg <= (wb.alu_addr != '0);
                        waddr_reg    <= wb.alu_addr;
                        data_in_reg  <= wb.alu_data;
                    end
                    SRC_LD: begin
                        write_en_reg <= (wb.ld_addr != '0);
                        ld_stage_reg <= 1'b1;
                        waddr_reg    <= wb.ld_addr;
                        data_in_reg  <= wb.ld_data;
                    end
                    default: begin
                        // waddr 0 keeps the normal write path inert
                        write_en_reg  <= 1'b1;
                        write_imm_reg <= 1'b1;
                        waddr_reg     <= '0;
                        imm_in_reg    <= wb.imm_data;
                    end
                endcase
            end
        end
    end

    // Per-register pending bit: set by load issue, cleared by the load's
    // write stage; a simultaneous set takes precedence over the clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            logic set_bit;
            logic clr_bit;
            assign set_bit = (gi != 0) && issue_valid && (issue_addr == D'(gi));
            assign clr_bit = write_en_reg && ld_stage_reg && (waddr_reg == D'(gi));
            assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
        end
    endgenerate

    // Scoreboard register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Hazard flags look at both the scoreboard and the write in flight,
    // since the register file only holds the new value after this cycle.
    always_comb begin
        hazardA    = (raddrA != '0) &&
                     (pending_reg[raddrA] ||
                      (write_en_reg && !write_imm_reg && (waddr_reg == raddrA)));
        hazardB    = pending_reg[raddrB] ||
                     (write_en_reg && !write_imm_reg && (waddr_reg == raddrB));
        rim_hazard = wb.imm_req || (write_en_reg && write_imm_reg);
    end

    assign write_en  = write_en_reg;
    assign write_imm = write_imm_reg;
    assign waddr     = waddr_reg;
    assign data_in   = data_in_reg;
    assign imm_in    = imm_in_reg;
    assign busy      = |pending_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a vector table with a queue of expected write
// records, followed by hand-written scoreboard, immediate, address-0 and
// mid-flight reset sequences.
module tb_rf_write_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       issue_valid;
    logic [2:0] issue_addr;
    logic [2:0] raddrA;
    logic [2:0] raddrB;
    logic       hazardA;
    logic       hazardB;
    logic       rim_hazard;
    logic       write_en;
    logic       write_imm;
    logic [2:0] waddr;
    logic [7:0] data_in;
    logic [7:0] imm_in;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter_if #(.W(8), .D(3)) wb ();

    rf_write_arbiter #(.W(8), .D(3)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .raddrA      (raddrA),
        .raddrB      (raddrB),
        .hazardA     (hazardA),
        .hazardB     (hazardB),
        .rim_hazard  (rim_hazard),
        .write_en    (write_en),
        .write_imm   (write_imm),
        .waddr       (waddr),
        .data_in     (data_in),
        .imm_in      (imm_in),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] req;       // {imm, ld, alu}
        logic [2:0] alu_addr;
        logic [7:0] alu_data;
        logic [2:0] ld_addr;
        logic [7:0] ld_data;
        logic [7:0] imm_data;
        logic [2:0] exp_gnt;   // {imm, ld, alu}
        logic       exp_we;
        logic       exp_wimm;
        logic [2:0] exp_waddr;
        logic [7:0] exp_data;
        logic [7:0] exp_imm;
        logic       chk_ad;    // compare waddr/data_in
    } vec_t;

    typedef struct {
        logic       we;
        logic       wimm;
        logic [2:0] waddr;
        logic [7:0] data;
        logic [7:0] imm;
        logic       chk_ad;
    } exp_t;

    vec_t vecs[12];
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] req,
                                input logic [2:0] aa, input logic [7:0] ad,
                                input logic [2:0] la, input logic [7:0] ldd,
                                input logic [7:0] id, input logic [2:0] g,
                                input logic we, input logic wi, input logic [2:0] wa,
                                input logic [7:0] d, input logic [7:0] im,
                                input logic ca);
        vec_t v;
        v.req = req; v.alu_addr = aa; v.alu_data = ad; v.ld_addr = la;
        v.ld_data = ldd; v.imm_data = id; v.exp_gnt = g; v.exp_we = we;
        v.exp_wimm = wi; v.exp_waddr = wa; v.exp_data = d; v.exp_imm = im;
        v.chk_ad = ca;
        return v;
    endfunction

    task automatic idle_inputs();
        wb.alu_req = 1'b0; wb.ld_req = 1'b0; wb.imm_req = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        wb.alu_req = 1'b1; wb.alu_addr = 3'd1; wb.alu_data = 8'h11;
        wb.ld_req  = 1'b1; wb.ld_addr  = 3'd2; wb.ld_data  = 8'h22;
        wb.imm_req = 1'b1; wb.imm_data = 8'h33;
        issue_valid = 1'b0; issue_addr = 3'd0;
        raddrA = 3'd1; raddrB = 3'd2;
        RST_N = 1'b0;

        //             req     alu        ld         imm    gnt    we wi wa    data   imm    chk
        vecs[0]  = mk(3'b111, 3'd1, 8'h11, 3'd2, 8'h22, 8'h33, 3'b001, 1, 0, 3'd1, 8'h11, 8'h00, 1);
        vecs[1]  = mk(3'b111, 3'd1, 8'h11, 3'd2, 8'h22, 8'h33, 3'b010, 1, 0, 3'd2, 8'h22, 8'h00, 1);
        vecs[2]  = mk(3'b111, 3'd1, 8'h11, 3'd2, 8'h22, 8'h33, 3'b100, 1, 1, 3'd0, 8'h22, 8'h33, 1);
        vecs[3]  = mk(3'b111, 3'd1, 8'h11, 3'd2, 8'h22, 8'h33, 3'b001, 1, 0, 3'd1, 8'h11, 8'h33, 1);
        vecs[4]  = mk(3'b000, 3'd1, 8'h11, 3'd2, 8'h22, 8'h33, 3'b000, 0, 0, 3'd1, 8'h11, 8'h33, 1);
        vecs[5]  = mk(3'b001, 3'd3, 8'h5A, 3'd2, 8'h22, 8'h33, 3'b001, 1, 0, 3'd3, 8'h5A, 8'h33, 1);
        vecs[6]  = mk(3'b100, 3'd3, 8'h5A, 3'd2, 8'h22, 8'hC3, 3'b100, 1, 1, 3'd0, 8'h5A, 8'hC3, 1);
        vecs[7]  = mk(3'b010, 3'd3, 8'h5A, 3'd4, 8'h44, 8'hC3, 3'b010, 1, 0, 3'd4, 8'h44, 8'hC3, 1);
        vecs[8]  = mk(3'b011, 3'd6, 8'h66, 3'd7, 8'h77, 8'hC3, 3'b001, 1, 0, 3'd6, 8'h66, 8'hC3, 1);
        vecs[9]  = mk(3'b011, 3'd6, 8'h66, 3'd7, 8'h77, 8'hC3, 3'b010, 1, 0, 3'd7, 8'h77, 8'hC3, 1);
        vecs[10] = mk(3'b101, 3'd6, 8'h66, 3'd7, 8'h77, 8'h99, 3'b100, 1, 1, 3'd0, 8'h77, 8'h99, 1);
        vecs[11] = mk(3'b001, 3'd0, 8'hAB, 3'd7, 8'h77, 8'h99, 3'b001, 0, 0, 3'd0, 8'hAB, 8'h99, 0);

        // Reset held two cycles with every request asserted.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt", {wb.imm_gnt, wb.ld_gnt, wb.alu_gnt}, 3'b000);
        chk("rst_we", write_en, 1'b0);
        chk("rst_wimm", write_imm, 1'b0);
        chk("rst_haz", {hazardA, hazardB}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", {waddr, data_in, imm_in}, '0);
        $display("txn reset gnt=%b we=%b busy=%b", {wb.imm_gnt, wb.ld_gnt, wb.alu_gnt}, write_en, busy);

        @(negedge CLK);
        RST_N = 1'b1;

        // Table: drive, check grant, queue expected write, check after edge.
        for (int i = 0; i < 12; i++) begin
            if (i != 0) @(negedge CLK);
            wb.alu_req = vecs[i].req[0]; wb.alu_addr = vecs[i].alu_addr; wb.alu_data = vecs[i].alu_data;
            wb.ld_req  = vecs[i].req[1]; wb.ld_addr  = vecs[i].ld_addr;  wb.ld_data  = vecs[i].ld_data;
            wb.imm_req = vecs[i].req[2]; wb.imm_data = vecs[i].imm_data;
            #1;
            chk($sformatf("v%0d_gnt", i), {wb.imm_gnt, wb.ld_gnt, wb.alu_gnt}, vecs[i].exp_gnt);
            e.we = vecs[i].exp_we; e.wimm = vecs[i].exp_wimm; e.waddr = vecs[i].exp_waddr;
            e.data = vecs[i].exp_data; e.imm = vecs[i].exp_imm; e.chk_ad = vecs[i].chk_ad;
            expq.push_back(e);
            @(posedge CLK);
            #1;
            e = expq.pop_front();
            chk($sformatf("v%0d_we", i), write_en, e.we);
            chk($sformatf("v%0d_wimm", i), write_imm, e.wimm);
            chk($sformatf("v%0d_imm", i), imm_in, e.imm);
            if (e.chk_ad) begin
                chk($sformatf("v%0d_waddr", i), waddr, e.waddr);
                chk($sformatf("v%0d_data", i), data_in, e.data);
            end
            $display("txn v%0d gnt=%b we=%b wimm=%b waddr=%0d data=%02h imm=%02h", i,
                     vecs[i].exp_gnt, write_en, write_imm, waddr, data_in, imm_in);
        end
        idle_inputs();

        // Single ALU write seen as a hazard during its write cycle.
        @(negedge CLK);
        wb.alu_req = 1'b1; wb.alu_addr = 3'd3; wb.alu_data = 8'h5A; raddrA = 3'd3; raddrB = 3'd6;
        #1;
        chk("alu_gnt", wb.alu_gnt, 1'b1);
        @(posedge CLK); #1;
        wb.alu_req = 1'b0;
        chk("alu_w", {write_en, write_imm, waddr, data_in}, {1'b1, 1'b0, 3'd3, 8'h5A});
        chk("alu_hazA", hazardA, 1'b1);
        chk("alu_hazB", hazardB, 1'b0);
        $display("txn alu_hazard hazardA=%b", hazardA);

        // Load issue marks register 5 pending.
        @(negedge CLK);
        issue_valid = 1'b1; issue_addr = 3'd5; raddrA = 3'd5; raddrB = 3'd5;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        chk("sb_busy", busy, 1'b1);
        chk("sb_haz", {hazardA, hazardB}, 2'b11);
        @(negedge CLK);
        wb.ld_req = 1'b1; wb.ld_addr = 3'd5; wb.ld_data = 8'h11;
        #1;
        chk("sb_ld_gnt", wb.ld_gnt, 1'b1);
        @(posedge CLK); #1;
        wb.ld_req = 1'b0;
        chk("sb_w", {write_en, waddr, data_in}, {1'b1, 3'd5, 8'h11});
        chk("sb_haz_wr", {hazardA, busy}, 2'b11);
        @(posedge CLK); #1;
        chk("sb_clr", {hazardA, hazardB, busy}, 3'b000);
        $display("txn scoreboard_clear busy=%b", busy);

        // Reissue during the clearing write keeps the register pending.
        @(negedge CLK);
        issue_valid = 1'b1; issue_addr = 3'd5;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        @(negedge CLK);
        wb.ld_req = 1'b1; wb.ld_addr = 3'd5; wb.ld_data = 8'h12;
        #1;
        chk("re_ld_gnt", wb.ld_gnt, 1'b1);
        @(posedge CLK); #1;
        wb.ld_req = 1'b0; issue_valid = 1'b1; issue_addr = 3'd5;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        chk("re_pending", {busy, hazardB, write_en}, 3'b110);
        @(negedge CLK);
        wb.ld_req = 1'b1;
        @(posedge CLK); #1;
        wb.ld_req = 1'b0;
        @(posedge CLK); #1;
        chk("re_clr", busy, 1'b0);
        $display("txn reissue busy=%b", busy);

        // Issue to register 0 is ignored.
        @(negedge CLK);
        issue_valid = 1'b1; issue_addr = 3'd0;
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        chk("issue0_busy", busy, 1'b0);

        // Immediate write and rim_hazard across both cycles.
        @(negedge CLK);
        wb.imm_req = 1'b1; wb.imm_data = 8'hC3;
        #1;
        chk("imm_gnt", wb.imm_gnt, 1'b1);
        chk("imm_rim0", rim_hazard, 1'b1);
        @(posedge CLK); #1;
        wb.imm_req = 1'b0;
        chk("imm_w", {write_en, write_imm, waddr, imm_in}, {1'b1, 1'b1, 3'd0, 8'hC3});
        chk("imm_rim1", rim_hazard, 1'b1);
        @(posedge CLK); #1;
        chk("imm_rim2", rim_hazard, 1'b0);
        $display("txn imm imm_in=%02h", imm_in);

        // ALU write to register 0: granted, dropped, no hazard on raddrA=0.
        @(negedge CLK);
        wb.alu_req = 1'b1; wb.alu_addr = 3'd0; wb.alu_data = 8'hEE; raddrA = 3'd0;
        #1;
        chk("z_gnt", wb.alu_gnt, 1'b1);
        @(posedge CLK); #1;
        wb.alu_req = 1'b0;
        chk("z_we", write_en, 1'b0);
        chk("z_hazA", hazardA, 1'b0);
        $display("txn addr0 we=%b", write_en);

        // Reset arriving right after a grant discards the write.
        @(negedge CLK);
        wb.alu_req = 1'b1; wb.alu_addr = 3'd2; wb.alu_data = 8'hEE;
        #1;
        chk("mr_gnt", wb.alu_gnt, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("mr_gnt_rst", wb.alu_gnt, 1'b0);
        @(posedge CLK); #1;
        wb.alu_req = 1'b0;
        chk("mr_we", write_en, 1'b0);
        chk("mr_data", data_in, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        $display("txn midreset we=%b", write_en);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
